// File: rtl/demux124_stream.sv
`default_nettype none
// ============================================================================
//  Module      : demux124_stream
//  Description : 1-to-4 valid/ready stream demultiplexer. Each accepted input
//                word is steered by Sel into one of four single-entry output
//                holding registers, each with its own valid/ready handshake.
//                A sticky Overflow flag reports a 256-cycle input stall.
//                Optional per-channel delivered-word counters are enabled by
//                defining the macro DEMUX124_CNT_EN (adds port Count).
//  Revision    : 1.0 - initial release
// ============================================================================
module demux124_stream #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] InData,
  input  logic             InValid,
  input  logic [1:0]       Sel,
  output logic             InReady,
  output logic [WIDTH-1:0] Out0,
  output logic [WIDTH-1:0] Out1,
  output logic [WIDTH-1:0] Out2,
  output logic [WIDTH-1:0] Out3,
  output logic [3:0]       OutValid,
  input  logic [3:0]       OutReady,
  output logic             Overflow
`ifdef DEMUX124_CNT_EN
  ,
  output logic [31:0]      Count
`endif
);

  localparam int NUM_CH = 4;

  logic [3:0]       valid_q;
  logic [WIDTH-1:0] data_q [NUM_CH];
  logic [3:0]       load;
  logic [3:0]       drain;
  logic             accept;
  logic             stall;
  logic [7:0]       stall_cnt;
  logic             overflow_q;

  // Handshake decode: a channel can take a new word when empty or draining
  // in the same cycle, which gives one word per cycle per channel.
  always_comb begin
    InReady = ~valid_q[Sel] | OutReady[Sel];
    accept  = InValid & InReady;
    load    = accept ? (4'b0001 << Sel) : 4'b0000;
    drain   = valid_q & OutReady;
    stall   = InValid & ~InReady;
  end

  // Channel valid flags: a load wins over a drain of the same channel.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= 4'b0000;
    end else begin
      valid_q <= load | (valid_q & ~drain);
    end
  end

  // Holding registers: only written on load, so they keep their last word
  // after draining and stay stable while a consumer stalls.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load[i]) begin
          data_q[i] <= InData;
        end
      end
    end
  end

  // Stall watchdog: 256 consecutive blocked cycles set a sticky flag that
  // only reset clears.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt  <= 8'd0;
      overflow_q <= 1'b0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 8'd1;
      if (stall_cnt == 8'hFF) begin
        overflow_q <= 1'b1;
      end
    end else begin
      stall_cnt <= 8'd0;
    end
  end

  assign Out0     = data_q[0];
  assign Out1     = data_q[1];
  assign Out2     = data_q[2];
  assign Out3     = data_q[3];
  assign OutValid = valid_q;
  assign Overflow = overflow_q;

`ifdef DEMUX124_CNT_EN
  logic [31:0] count_q;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
      // Delivered-word counter for channel g, wrapping at 255.
      always_ff @(posedge Clk) begin
        if (Reset) begin
          count_q[8*g +: 8] <= 8'd0;
        end else if (drain[g]) begin
          count_q[8*g +: 8] <= count_q[8*g +: 8] + 8'd1;
        end
      end
    end
  endgenerate

  assign Count = count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux124_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux124_stream
//  Description : Self-checking bench for demux124_stream. A vector table
//                drives the handshake cases; per-channel queues hold the
//                words expected at each output in order of acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux124_stream;

  logic       Clk;
  logic       Reset;
  logic [7:0] InData;
  logic       InValid;
  logic [1:0] Sel;
  logic       InReady;
  logic [7:0] Out0, Out1, Out2, Out3;
  logic [3:0] OutValid;
  logic [3:0] OutReady;
  logic       Overflow;
`ifdef DEMUX124_CNT_EN
  logic [31:0] Count;
`endif

  demux124_stream #(.WIDTH(8)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .InData   (InData),
    .InValid  (InValid),
    .Sel      (Sel),
    .InReady  (InReady),
    .Out0     (Out0),
    .Out1     (Out1),
    .Out2     (Out2),
    .Out3     (Out3),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Overflow (Overflow)
`ifdef DEMUX124_CNT_EN
    ,
    .Count    (Count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [7:0] outs [4];
  assign outs[0] = Out0;
  assign outs[1] = Out1;
  assign outs[2] = Out2;
  assign outs[3] = Out3;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sbq [4][$];

  typedef struct {
    logic       v;
    logic [1:0] s;
    logic [7:0] d;
    logic [3:0] r;
    logic       exp_rdy;
    logic [3:0] exp_ov;
    logic       chk_en;
    logic [1:0] chk_ch;
    logic [7:0] chk_d;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, run the scoreboard before the edge,
  // then return #1 after the edge with the registered outputs settled.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [7:0] d,
                       input logic [3:0] r, output logic rdy_seen);
    logic [7:0] e;
    InValid  = v;
    Sel      = s;
    InData   = d;
    OutReady = r;
    @(negedge Clk);
    rdy_seen = InReady;
    if (!Reset) begin
      for (int i = 0; i < 4; i++) begin
        if (OutValid[i] && OutReady[i]) begin
          if (sbq[i].size() == 0) begin
            chk("sb_unexpected_word", 32'(i), 32'hFFFF_FFFF);
          end else begin
            e = sbq[i].pop_front();
            chk("sb_channel_data", {24'd0, outs[i]}, {24'd0, e});
          end
        end
      end
      if (InValid && InReady) sbq[Sel].push_back(InData);
    end
    @(posedge Clk);
    #1;
  endtask

  logic rdy;

  initial begin
    Reset = 1'b0; InValid = 1'b0; Sel = 2'd0; InData = 8'd0; OutReady = 4'd0;

    //                 v     s     d      r       rdy   ov_after chk ch    data
    vecs[0]  = '{1'b1, 2'd0, 8'h11, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    vecs[1]  = '{1'b1, 2'd1, 8'h22, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
    vecs[2]  = '{1'b1, 2'd2, 8'h33, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33};
    vecs[3]  = '{1'b1, 2'd3, 8'h44, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
    vecs[4]  = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd3, 8'h44};
    vecs[5]  = '{1'b1, 2'd1, 8'h5A, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h5A};
    vecs[6]  = '{1'b1, 2'd1, 8'hC3, 4'b1101, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h5A};
    vecs[7]  = '{1'b1, 2'd3, 8'hC3, 4'b1101, 1'b1, 4'b1010, 1'b1, 2'd3, 8'hC3};
    vecs[8]  = '{1'b0, 2'd0, 8'h00, 4'b1101, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h5A};
    vecs[9]  = '{1'b1, 2'd2, 8'h99, 4'b0000, 1'b1, 4'b0110, 1'b1, 2'd2, 8'h99};
    vecs[10] = '{1'b1, 2'd2, 8'h7E, 4'b0100, 1'b1, 4'b0110, 1'b1, 2'd2, 8'h7E};
    vecs[11] = '{1'b0, 2'd3, 8'hEE, 4'b0000, 1'b1, 4'b0110, 1'b1, 2'd1, 8'h5A};
    vecs[12] = '{1'b0, 2'd1, 8'h00, 4'b0110, 1'b1, 4'b0000, 1'b1, 2'd2, 8'h7E};
    vecs[13] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd1, 8'h5A};

    @(posedge Clk); #1;

    // Reset with a live input word in the reset cycle.
    Reset = 1'b1;
    cycle(1'b1, 2'd2, 8'hAA, 4'b0000, rdy);
    chk("reset_outvalid", {28'd0, OutValid}, 32'd0);
    chk("reset_out0", {24'd0, Out0}, 32'd0);
    chk("reset_out1", {24'd0, Out1}, 32'd0);
    chk("reset_out2", {24'd0, Out2}, 32'd0);
    chk("reset_out3", {24'd0, Out3}, 32'd0);
    chk("reset_overflow", {31'd0, Overflow}, 32'd0);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) sbq[i].delete();

    // Table-driven handshake vectors.
    for (int k = 0; k < 14; k++) begin
      cycle(vecs[k].v, vecs[k].s, vecs[k].d, vecs[k].r, rdy);
      chk($sformatf("vec%0d_inready", k), {31'd0, rdy}, {31'd0, vecs[k].exp_rdy});
      chk($sformatf("vec%0d_outvalid", k), {28'd0, OutValid}, {28'd0, vecs[k].exp_ov});
      if (vecs[k].chk_en)
        chk($sformatf("vec%0d_out%0d", k, vecs[k].chk_ch),
            {24'd0, outs[vecs[k].chk_ch]}, {24'd0, vecs[k].chk_d});
    end

    // Overflow: fill channel 0, then stall it for 256 cycles.
    cycle(1'b1, 2'd0, 8'h01, 4'b0000, rdy);
    chk("ovf_fill_accept", {31'd0, rdy}, 32'd1);
    for (int n = 0; n < 255; n++) cycle(1'b1, 2'd0, 8'hFF, 4'b0000, rdy);
    chk("ovf_after_255", {31'd0, Overflow}, 32'd0);
    cycle(1'b1, 2'd0, 8'hFF, 4'b0000, rdy);
    chk("ovf_stall_inready", {31'd0, rdy}, 32'd0);
    chk("ovf_after_256", {31'd0, Overflow}, 32'd1);
    cycle(1'b0, 2'd0, 8'h00, 4'b0001, rdy);
    chk("ovf_sticky", {31'd0, Overflow}, 32'd1);
    chk("ovf_drained", {28'd0, OutValid}, 32'd0);

    // Reset mid-operation with a stalled held word.
    cycle(1'b1, 2'd1, 8'h55, 4'b0000, rdy);
    chk("mid_load", {28'd0, OutValid}, 32'b0010);
    Reset = 1'b1;
    cycle(1'b1, 2'd3, 8'h66, 4'b0000, rdy);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) sbq[i].delete();
    chk("mid_reset_outvalid", {28'd0, OutValid}, 32'd0);
    chk("mid_reset_out1", {24'd0, Out1}, 32'd0);
    chk("mid_reset_overflow", {31'd0, Overflow}, 32'd0);
    cycle(1'b0, 2'd1, 8'h00, 4'b0000, rdy);
    chk("post_reset_inready", {31'd0, rdy}, 32'd1);

`ifdef DEMUX124_CNT_EN
    // 257 words through channel 3 wrap its counter to 1.
    for (int n = 0; n < 257; n++) cycle(1'b1, 2'd3, 8'(n), 4'b1000, rdy);
    cycle(1'b0, 2'd0, 8'h00, 4'b1000, rdy);
    chk("count_wrap", Count, 32'h0100_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux124_stream.md
Name: demux124_stream

Overview:
- 1-to-4 stream demultiplexer; the distribution counterpart of the team's 4:1 mux blocks.
- Takes one valid/ready input stream and a 2-bit select, and steers each accepted word into one of four output channels.
- Each output channel has its own single-entry holding register and valid/ready handshake.
- Sits between a single producer and four independent consumers. Serves as a known-good DUT for the team's demux verification exercises.

Parameters:
- WIDTH, 8, data width of the input and of each output channel.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- InData  input  WIDTH  input word.
- InValid  input  1  input word present.
- Sel  input  2  destination channel for the current input word; sampled only when InValid=1.
- InReady  output  1  block can accept the current word.
- Out0, Out1, Out2, Out3  output  WIDTH  channel data, driven from the holding registers.
- OutValid  output  4  bit i set: channel i holds a word.
- OutReady  input  4  bit i set: consumer i takes the word this cycle.
- Overflow  output  1  sticky error flag (see Behaviour).

Behaviour:
- All state updates on the rising edge of Clk. Reset is synchronous and active-high, and overrides every other event in the same cycle.
- Reset values:
  - OutValid = 4'b0000.
  - Out0..Out3 = 0.
  - Overflow = 0.
  - Counters (optional feature) = 0.
- InReady is combinational: InReady = ~OutValid[Sel] | OutReady[Sel]. With the reset state this gives InReady=1 after reset.
- Accept: InValid & InReady in cycle N.
  - Out[Sel] <= InData.
  - OutValid[Sel] <= 1, visible in cycle N+1.
  - Latency is exactly 1 cycle.
- Drain: OutValid[i] & OutReady[i] in a cycle clears OutValid[i] at the next edge, unless the same cycle also loads channel i.
- Simultaneous drain and load of the same channel:
  - Register takes the new word; OutValid[i] stays 1.
  - Gives full throughput of 1 word/cycle per channel.
- Channels are independent:
  - A stalled channel (OutValid=1, OutReady=0) blocks only inputs selected to it.
  - Other channels keep draining.
  - Input words are never reordered within a channel.
- Stable hold: while OutValid[i]=1 and OutReady[i]=0, Out_i and OutValid[i] do not change.
- OutReady[i] has no effect when OutValid[i]=0.
- Out_i retains its last value after draining; it is not cleared.
- Overflow:
  - Set when InValid=1 and InReady=0 for 256 consecutive cycles, counted by an 8-bit stall counter.
  - The stall counter clears whenever that condition is false.
  - Overflow is cleared only by Reset.
- Reset mid-operation: any held words are discarded, all OutValid drop the next cycle, and no partial transfers remain.
- Sel or InData changing while InValid=0 has no effect.

Optional Feature:
- Macro: DEMUX124_CNT_EN.
- Defined:
  - Adds output port Count, 32 bits wide: four 8-bit per-channel delivered-word counters, channel i at bits [8i+7:8i].
  - Counter i increments on each drain of channel i and wraps 255 -> 0.
  - Counters reset to 0 on Reset.
- Undefined: no Count port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset with InValid=1, Sel=2, InData=8'hAA asserted in the reset cycle -> OutValid=0000 and Out0..Out3=0 in the next cycle. InReady=1 once Reset is low.
- Sel=0..3 with InData=8'h11,22,33,44 on consecutive cycles, OutReady=1111 -> OutValid shows a one-hot walk 0001,0010,0100,1000 one cycle after each accept; Out_i matches its word.
- Channel 1 stalled (OutReady[1]=0) holding 8'h5A; input Sel=1, InData=8'hC3 -> InReady=0 and Out1 stays 8'h5A. The same cycle with Sel=3 is accepted, and Out3=8'hC3 the next cycle.
- Channel 2 full; in one cycle apply OutReady[2]=1 and an input with Sel=2, InData=8'h7E -> accepted, OutValid[2] stays 1, Out2=8'h7E.
- Channel 0 stalled with InValid=1, Sel=0 for 256 cycles -> Overflow rises after cycle 256. It stays 1 after the stall clears, and is cleared only by Reset.
- With DEMUX124_CNT_EN defined, drain 257 words through channel 3 -> Count[31:24]=1 (wrapped), other channel counters 0.
